// File: rtl/por.sv
// Single-port register-file RAM with registered read data and asynchronous clear.
// Define POR_WRITE_THROUGH_EN to make write edges also load out with the write data.
module por #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    output logic [DATA_W-1:0] out
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Every word clears on reset so never-written addresses read back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (!we) begin
            out <= mem[addr];
        end
`ifdef POR_WRITE_THROUGH_EN
        else begin
            out <= data;
        end
`endif
    end

endmodule

// File: tb/tb_por.sv
// Self-checking bench for por: directed scenarios plus random traffic against
// an array-based reference memory.
module tb_por;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data  = '0;
    logic [AW-1:0] addr  = '0;
    logic          we    = 1'b0;
    logic [DW-1:0] out;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_out;

    always #5 clk = ~clk;

    por #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .data (data),
        .addr (addr),
        .we   (we),
        .out  (out)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_out = '0;
    endtask

    // Drive one operation (called between edges), update the model at the edge,
    // then compare out shortly after the edge.
    task automatic step(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input string tag);
        we   = w;
        addr = a;
        data = d;
        @(posedge clk);
        if (w) begin
            ref_mem[a] = d;
`ifdef POR_WRITE_THROUGH_EN
            ref_out = d;
`endif
        end else begin
            ref_out = ref_mem[a];
        end
        #1;
        check(tag, out, ref_out);
    endtask

    logic [DW-1:0] held;

    initial begin
        ref_reset();

        // Reset: out is zero, and edges while held in reset are ignored.
        #2;
        check("reset_out", out, 8'h00);
        we = 1'b1; addr = 6'd7; data = 8'hff;
        @(posedge clk);
        #2;
        check("reset_ignore_out", out, 8'h00);
        rst_n = 1'b1;
        we = 1'b0;
        step(1'b0, 6'd7, 8'h00, "reset_ignore_mem");
        check("reset_ignore_mem_const", out, 8'h00);

        // Basic write/read ordering.
        step(1'b1, 6'd1, 8'hb4, "wr1");
        step(1'b1, 6'd2, 8'h74, "wr2");
        step(1'b1, 6'd3, 8'hc3, "wr3");
        step(1'b0, 6'd2, 8'h00, "rd2");
        check("rd2_const", out, 8'h74);
        step(1'b0, 6'd1, 8'h00, "rd1");
        check("rd1_const", out, 8'hb4);

        // No aliasing between neighbouring addresses.
        step(1'b1, 6'd50, 8'h5c, "wr50");
        step(1'b1, 6'd51, 8'hab, "wr51");
        step(1'b0, 6'd50, 8'h00, "rd50");
        check("rd50_const", out, 8'h5c);
        step(1'b0, 6'd51, 8'h00, "rd51");
        check("rd51_const", out, 8'hab);
        step(1'b0, 6'd3, 8'h00, "rd3");
        check("rd3_const", out, 8'hc3);

        // Boundary addresses.
        step(1'b1, 6'd63, 8'h3c, "wr63");
        step(1'b0, 6'd63, 8'h00, "rd63");
        check("rd63_const", out, 8'h3c);
        step(1'b0, 6'd0, 8'h00, "rd0");
        check("rd0_const", out, 8'h00);

        // Write-cycle behaviour of out.
        step(1'b0, 6'd2, 8'h00, "rd2_again");
        step(1'b1, 6'd5, 8'hc3, "wr5_out");
`ifdef POR_WRITE_THROUGH_EN
        check("wr5_out_const", out, 8'hc3);
`else
        check("wr5_out_const", out, 8'h74);
`endif
        step(1'b0, 6'd5, 8'h00, "rd5");

        // Between-edge activity does not reach out or mem.
        step(1'b0, 6'd2, 8'h00, "rd2_hold");
        held = out;
        for (int i = 0; i < 4; i++) begin
            addr = 6'($urandom_range(0, DEPTH - 1));
            #1;
            check("addr_glitch_hold", out, held);
        end
        we = 1'b1; addr = 6'd9; data = 8'haa;
        #1;
        check("we_glitch_hold", out, held);
        we = 1'b0;
        step(1'b0, 6'd9, 8'h00, "we_glitch_mem");

        // Reset pulse mid-cycle clears out immediately and wipes memory.
        step(1'b1, 6'd1, 8'hb4, "wr1_pre_rst");
        step(1'b0, 6'd1, 8'h00, "rd1_pre_rst");
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_pulse_out", out, 8'h00);
        ref_reset();
        #1;
        rst_n = 1'b1;
        step(1'b0, 6'd1, 8'h00, "rd1_post_rst");
        check("rd1_post_rst_const", out, 8'h00);

        // Random traffic against the reference array.
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            case ($urandom_range(0, 7))
                0:       a = '0;
                1:       a = '1;
                default: a = AW'($urandom_range(0, DEPTH - 1));
            endcase
            step(1'($urandom_range(0, 1)), a, DW'($urandom_range(0, 255)), "rand");
        end

        // Full readback sweep.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, AW'(i), 8'h00, "sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/por.md
POR -- requirements
Module: por

Interface
REQ-001 Parameter DATA_W, default 8: width of each stored word and of data/out.
REQ-002 Parameter ADDR_W, default 6: address width; depth DEPTH = 2**ADDR_W (64 words).
REQ-003 clk  input  1  single clock; all state changes on its rising edge except reset.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data  input  DATA_W  write data.
REQ-006 addr  input  ADDR_W  word address for both write and read.
REQ-007 we  input  1  write enable, 1 = write, 0 = read.
REQ-008 out  output  DATA_W  registered read data.

Function
REQ-009 The block SHALL be a single-port synchronous RAM of DEPTH words of DATA_W bits each, built from registers.
REQ-010 On a rising clk edge with we=1, the block SHALL store data into mem[addr].
REQ-011 On a rising clk edge with we=0, the block SHALL load out with mem[addr], giving one-cycle read latency.
REQ-012 With we=0, mem SHALL be unchanged.
REQ-013 A read of an address in the cycle after it was written SHALL return the newly written value.
REQ-014 out SHALL change only on a rising clk edge or on reset assertion, never combinationally from addr, data or we.
REQ-015 Every address 0..DEPTH-1 SHALL be valid; there is no out-of-range case and addresses do not wrap.
REQ-016 Inputs SHALL be sampled only at the rising edge; glitches between edges have no effect.

Reset
REQ-017 While rst_n=0, out SHALL be 0 and every mem word SHALL be 0, asynchronously to clk.
REQ-018 While rst_n=0, writes and reads SHALL be ignored.
REQ-019 A write or read in progress when rst_n asserts SHALL be discarded.
REQ-020 On the first rising edge after rst_n deasserts, normal operation SHALL resume.
REQ-021 A read of a never-written address after reset SHALL return 0.

Configuration
REQ-022 Macro POR_WRITE_THROUGH_EN SHALL select the out behaviour on write cycles.
REQ-023 With POR_WRITE_THROUGH_EN defined, a write edge (we=1) SHALL also load out with data (write-first).
REQ-024 Without POR_WRITE_THROUGH_EN, out SHALL hold its previous value on write edges.
REQ-025 Memory contents SHALL be identical in both configurations.

Verification
REQ-026 Reset, then write b4@1, 74@2, c3@3, then read addr 2 -> out=74 one edge later; then read addr 1 -> out=b4.
REQ-027 Write 5c@50, then ab@51, then read 50 -> out=5c; read 51 -> out=ab; read 3 -> out=c3 (no aliasing between addresses).
REQ-028 Write 3c@63, read 63 -> 3c; read 0 (never written) -> 00 (boundary addresses).
REQ-029 Write b4@1, pulse rst_n low mid-cycle -> out=00 immediately; after release, read 1 -> 00.
REQ-030 Out holds 74 after reading addr 2, then write c3@5 -> out=c3 with POR_WRITE_THROUGH_EN, out stays 74 without it.
REQ-031 Change addr between edges with we=0 -> out stays constant until the next rising edge.
